// File: rtl/fpu_collect_pkg.sv
// Shared types for the FPU result collector: controller state encoding,
// the packed capture record layout and its width.
package fpu_collect_pkg;

    localparam int FPU_DATA_WIDTH = 32;
    localparam int REC_WIDTH      = FPU_DATA_WIDTH + 3;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CAPTURE = 2'd1,
        DONE    = 2'd2,
        DUMP    = 2'd3
    } collect_state_e;

    // One captured FPU result, MSB first: op type, overflow, underflow, value.
    typedef struct packed {
        logic                      add_sub;
        logic                      ov;
        logic                      un;
        logic [FPU_DATA_WIDTH-1:0] s;
    } fpu_rec_t;

    // Assemble a record from its individual fields.
    function automatic fpu_rec_t rec_pack(input logic add_sub,
                                          input logic ov,
                                          input logic un,
                                          input logic [FPU_DATA_WIDTH-1:0] s);
        fpu_rec_t r;
        r.add_sub = add_sub;
        r.ov      = ov;
        r.un      = un;
        r.s       = s;
        return r;
    endfunction

endpackage

// File: rtl/fpu_result_collector_ram.sv
// Record buffer: one write port, one registered read port (1-cycle latency).
// The read register only updates when i_re is high, so the last read value
// is held stable for as long as the reader stalls. Memory is not reset.
module simple_dual_port_ram #(
    parameter int DATA_WIDTH = 35,
    parameter int ADDR_WIDTH = 5
) (
    input  logic                  i_clk,
    input  logic                  i_we,
    input  logic [ADDR_WIDTH-1:0] i_waddr,
    input  logic [DATA_WIDTH-1:0] i_wdata,
    input  logic                  i_re,
    input  logic [ADDR_WIDTH-1:0] i_raddr,
    output logic [DATA_WIDTH-1:0] o_rdata
);

    logic [DATA_WIDTH-1:0] mem_q [2**ADDR_WIDTH];
    logic [DATA_WIDTH-1:0] rdata_q;

    // Synchronous write and enabled, registered read.
    always_ff @(posedge i_clk) begin
        if (i_we) begin
            mem_q[i_waddr] <= i_wdata;
        end
        if (i_re) begin
            rdata_q <= mem_q[i_raddr];
        end
    end

    assign o_rdata = rdata_q;

endmodule

// File: rtl/fpu_result_collector.sv
// FPU result collector: captures {add_sub, ov, un, s} records into a buffer
// while counting overflow/underflow flags, then replays them in order over a
// valid/ready stream.
// Optional running checksum of captured results: define FPU_COLLECT_CHECKSUM_EN.
//
// Replay pipeline: the RAM read register is stage A, the output register is
// stage B. A record moves A->B when B is empty or being accepted, and a new
// read is issued whenever A is empty or moving, giving 1 record/cycle under
// continuous ready and first valid two cycles after the dump request.
module fpu_result_collector
    import fpu_collect_pkg::*;
#(
    parameter int SIZE_ADDR  = 5,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_start,
    input  logic                  i_stop,
    input  logic                  i_valid,
    output logic                  o_ready,
    input  logic [DATA_WIDTH-1:0] i_32_s,
    input  logic                  i_ov_flag,
    input  logic                  i_un_flag,
    input  logic                  i_add_sub,
    input  logic                  i_dump_start,
    output logic                  o_rd_valid,
    input  logic                  i_rd_ready,
    output logic [DATA_WIDTH+2:0] o_rd_data,
    output logic [SIZE_ADDR:0]    o_count,
    output logic [SIZE_ADDR:0]    o_ov_cnt,
    output logic [SIZE_ADDR:0]    o_un_cnt,
    output logic                  o_busy,
    output logic                  o_done,
    output logic [DATA_WIDTH-1:0] o_checksum
);

    localparam int                RW        = DATA_WIDTH + 3;
    localparam int                DEPTH     = 2**SIZE_ADDR;
    localparam logic [SIZE_ADDR:0] DEPTH_CNT = (SIZE_ADDR+1)'(DEPTH);
    localparam logic [SIZE_ADDR:0] CNT_ZERO  = {(SIZE_ADDR+1){1'b0}};
    localparam logic [SIZE_ADDR:0] CNT_ONE   = {{SIZE_ADDR{1'b0}}, 1'b1};

    collect_state_e       state_q, state_d;
    logic [SIZE_ADDR:0]   count_q, count_d;
    logic [SIZE_ADDR:0]   ov_cnt_q, ov_cnt_d;
    logic [SIZE_ADDR:0]   un_cnt_q, un_cnt_d;
    logic [SIZE_ADDR:0]   rd_ptr_q, rd_ptr_d;
    logic                 a_vld_q, a_vld_d;
    logic                 b_vld_q, b_vld_d;
    logic [RW-1:0]        b_data_q, b_data_d;
    logic                 ready_q, ready_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;

    logic                 accept_s;
    logic                 clear_s;
    logic                 b_load_s;
    logic                 issue_s;
    logic                 ram_re_s;
    logic [SIZE_ADDR-1:0] ram_raddr_s;
    logic [RW-1:0]        ram_rdata_s;
    logic [RW-1:0]        ram_wdata_s;

    assign ram_wdata_s = {i_add_sub, i_ov_flag, i_un_flag, i_32_s};

    // The record count doubles as the write pointer: records land at 0..count-1.
    simple_dual_port_ram #(
        .DATA_WIDTH (RW),
        .ADDR_WIDTH (SIZE_ADDR)
    ) u_ram (
        .i_clk   (i_clk),
        .i_we    (accept_s),
        .i_waddr (count_q[SIZE_ADDR-1:0]),
        .i_wdata (ram_wdata_s),
        .i_re    (ram_re_s),
        .i_raddr (ram_raddr_s),
        .o_rdata (ram_rdata_s)
    );

    // Next-state, counter and replay-pipeline logic.
    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        ov_cnt_d    = ov_cnt_q;
        un_cnt_d    = un_cnt_q;
        rd_ptr_d    = rd_ptr_q;
        a_vld_d     = a_vld_q;
        b_vld_d     = b_vld_q;
        b_data_d    = b_data_q;
        accept_s    = 1'b0;
        clear_s     = 1'b0;
        issue_s     = 1'b0;
        ram_re_s    = 1'b0;
        ram_raddr_s = rd_ptr_q[SIZE_ADDR-1:0];
        b_load_s    = a_vld_q && (!b_vld_q || i_rd_ready);

        case (state_q)
            IDLE: begin
                if (i_start) begin
                    clear_s  = 1'b1;
                    state_d  = CAPTURE;
                    count_d  = CNT_ZERO;
                    ov_cnt_d = CNT_ZERO;
                    un_cnt_d = CNT_ZERO;
                end else begin
                    state_d = IDLE;
                end
            end

            CAPTURE: begin
                accept_s = i_valid && ready_q;
                if (accept_s) begin
                    count_d  = count_q + CNT_ONE;
                    ov_cnt_d = ov_cnt_q + {{SIZE_ADDR{1'b0}}, i_ov_flag};
                    un_cnt_d = un_cnt_q + {{SIZE_ADDR{1'b0}}, i_un_flag};
                end else begin
                    count_d  = count_q;
                end
                if (i_stop || (count_d == DEPTH_CNT)) begin
                    state_d = DONE;
                end else begin
                    state_d = CAPTURE;
                end
            end

            DONE: begin
                if (i_start) begin
                    clear_s  = 1'b1;
                    state_d  = CAPTURE;
                    count_d  = CNT_ZERO;
                    ov_cnt_d = CNT_ZERO;
                    un_cnt_d = CNT_ZERO;
                end else if (i_dump_start) begin
                    state_d  = DUMP;
                    a_vld_d  = 1'b0;
                    b_vld_d  = 1'b0;
                    rd_ptr_d = CNT_ZERO;
                    // Read record 0 right away so the first beat arrives two cycles on.
                    if (count_q != CNT_ZERO) begin
                        ram_re_s    = 1'b1;
                        ram_raddr_s = {SIZE_ADDR{1'b0}};
                        rd_ptr_d    = CNT_ONE;
                        a_vld_d     = 1'b1;
                    end else begin
                        rd_ptr_d    = CNT_ZERO;
                    end
                end else begin
                    state_d = DONE;
                end
            end

            DUMP: begin
                if (b_vld_q && i_rd_ready) begin
                    b_vld_d = 1'b0;
                end else begin
                    b_vld_d = b_vld_q;
                end
                if (b_load_s) begin
                    b_vld_d  = 1'b1;
                    b_data_d = ram_rdata_s;
                end else begin
                    b_data_d = b_data_q;
                end
                issue_s = (rd_ptr_q != count_q) && (!a_vld_q || b_load_s);
                if (issue_s) begin
                    ram_re_s = 1'b1;
                    rd_ptr_d = rd_ptr_q + CNT_ONE;
                    a_vld_d  = 1'b1;
                end else if (b_load_s) begin
                    a_vld_d  = 1'b0;
                end else begin
                    a_vld_d  = a_vld_q;
                end
                // Everything issued, nothing in flight and the output drained.
                if ((rd_ptr_q == count_q) && !a_vld_q && (!b_vld_q || i_rd_ready)) begin
                    state_d = DONE;
                end else begin
                    state_d = DUMP;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Status outputs are registered from the next state so they line up with it.
    always_comb begin
        ready_d = (state_d == CAPTURE) && (count_d < DEPTH_CNT);
        busy_d  = (state_d == CAPTURE) || (state_d == DUMP);
        done_d  = (state_d == DONE);
    end

    // State, counters and replay registers.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q  <= IDLE;
            count_q  <= CNT_ZERO;
            ov_cnt_q <= CNT_ZERO;
            un_cnt_q <= CNT_ZERO;
            rd_ptr_q <= CNT_ZERO;
            a_vld_q  <= 1'b0;
            b_vld_q  <= 1'b0;
            b_data_q <= {RW{1'b0}};
            ready_q  <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            ov_cnt_q <= ov_cnt_d;
            un_cnt_q <= un_cnt_d;
            rd_ptr_q <= rd_ptr_d;
            a_vld_q  <= a_vld_d;
            b_vld_q  <= b_vld_d;
            b_data_q <= b_data_d;
            ready_q  <= ready_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

`ifdef FPU_COLLECT_CHECKSUM_EN
    logic [DATA_WIDTH-1:0] chk_q, chk_d;

    // Rotate-left-and-xor signature over every accepted result.
    always_comb begin
        chk_d = chk_q;
        if (clear_s) begin
            chk_d = {DATA_WIDTH{1'b0}};
        end else if (accept_s) begin
            chk_d = {chk_q[DATA_WIDTH-2:0], chk_q[DATA_WIDTH-1]} ^ i_32_s;
        end else begin
            chk_d = chk_q;
        end
    end

    // Checksum register.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            chk_q <= {DATA_WIDTH{1'b0}};
        end else begin
            chk_q <= chk_d;
        end
    end

    assign o_checksum = chk_q;
`else
    assign o_checksum = {DATA_WIDTH{1'b0}};
`endif

    assign o_ready    = ready_q;
    assign o_busy     = busy_q;
    assign o_done     = done_q;
    assign o_count    = count_q;
    assign o_ov_cnt   = ov_cnt_q;
    assign o_un_cnt   = un_cnt_q;
    assign o_rd_valid = b_vld_q;
    assign o_rd_data  = b_data_q;

endmodule

// File: tb/tb_fpu_result_collector.sv
// Scoreboard bench for fpu_result_collector. A queue-based model tracks what
// should be captured; replay expectations are queued when a dump starts and a
// negedge monitor pops and compares every accepted replay beat.
module tb_fpu_result_collector;
    import fpu_collect_pkg::*;

    localparam int SA    = 5;
    localparam int DW    = 32;
    localparam int DEPTH = 32;

    logic          i_clk = 1'b0;
    logic          i_rst_n, i_start, i_stop, i_valid, o_ready;
    logic [DW-1:0] i_32_s;
    logic          i_ov_flag, i_un_flag, i_add_sub, i_dump_start;
    logic          o_rd_valid, i_rd_ready;
    logic [DW+2:0] o_rd_data;
    logic [SA:0]   o_count, o_ov_cnt, o_un_cnt;
    logic          o_busy, o_done;
    logic [DW-1:0] o_checksum;

    int n_checks = 0;
    int n_fail   = 0;

    logic [DW+2:0] exp_q[$];
    logic [DW+2:0] mon_exp;
    logic [DW+2:0] prev_data;
    logic [DW+2:0] last_rd;
    bit            prev_hold = 1'b0;

    // Reference model: captured records plus running statistics.
    fpu_rec_t      m_buf[$];
    bit            m_cap, m_done;
    int            m_ov, m_un;
    logic [DW-1:0] m_chk;

    fpu_result_collector #(.SIZE_ADDR(SA), .DATA_WIDTH(DW)) dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_start(i_start), .i_stop(i_stop),
        .i_valid(i_valid), .o_ready(o_ready), .i_32_s(i_32_s),
        .i_ov_flag(i_ov_flag), .i_un_flag(i_un_flag), .i_add_sub(i_add_sub),
        .i_dump_start(i_dump_start), .o_rd_valid(o_rd_valid), .i_rd_ready(i_rd_ready),
        .o_rd_data(o_rd_data), .o_count(o_count), .o_ov_cnt(o_ov_cnt),
        .o_un_cnt(o_un_cnt), .o_busy(o_busy), .o_done(o_done), .o_checksum(o_checksum)
    );

    always #5 i_clk = ~i_clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    task automatic model_clear();
        m_buf.delete();
        m_ov  = 0;
        m_un  = 0;
        m_chk = '0;
    endtask

    task automatic do_start();
        i_start = 1'b1;
        step();
        i_start = 1'b0;
        model_clear();
        m_cap  = 1'b1;
        m_done = 1'b0;
    endtask

    // One capture cycle; the model decides on its own whether it is accepted.
    task automatic cap(input bit v, input logic [DW-1:0] d, input bit ov, input bit un,
                       input bit as, input bit stop);
        bit rdy;
        rdy = m_cap && (m_buf.size() < DEPTH);
        i_valid = v; i_32_s = d; i_ov_flag = ov; i_un_flag = un; i_add_sub = as; i_stop = stop;
        check("o_ready", 64'(o_ready), 64'(rdy));
        step();
        i_valid = 1'b0; i_stop = 1'b0;
        if (v && rdy) begin
            m_buf.push_back(rec_pack(as, ov, un, d));
            m_ov  += int'(ov);
            m_un  += int'(un);
            m_chk  = ((m_chk << 1) | (m_chk >> (DW-1))) ^ d;
        end
        if (m_cap && (stop || m_buf.size() == DEPTH)) begin
            m_cap  = 1'b0;
            m_done = 1'b1;
        end
    endtask

    task automatic check_stats(input string tag);
        check({tag, "_count"}, 64'(o_count), 64'(m_buf.size()));
        check({tag, "_ov"},    64'(o_ov_cnt), 64'(m_ov));
        check({tag, "_un"},    64'(o_un_cnt), 64'(m_un));
        check({tag, "_done"},  64'(o_done), 64'(m_done));
        check({tag, "_busy"},  64'(o_busy), 64'(m_cap));
`ifdef FPU_COLLECT_CHECKSUM_EN
        check({tag, "_chk"},   64'(o_checksum), 64'(m_chk));
`else
        check({tag, "_chk"},   64'(o_checksum), 64'd0);
`endif
    endtask

    // Replay the model buffer; mode 0 toggles ready, 1 random, 2 always ready.
    task automatic dump(input int mode);
        int cyc;
        int n;
        n = m_buf.size();
        foreach (m_buf[i]) exp_q.push_back(m_buf[i]);
        i_rd_ready   = 1'b0;
        i_dump_start = 1'b1;
        step();
        i_dump_start = 1'b0;
        check("dump_busy", 64'(o_busy), 64'd1);
        check("dump_lat0", 64'(o_rd_valid), 64'd0);
        cyc = 0;
        while ((exp_q.size() != 0 || o_busy) && cyc < 300) begin
            case (mode)
                0:       i_rd_ready = (cyc % 2 == 0);
                1:       i_rd_ready = 1'($urandom_range(0, 1));
                default: i_rd_ready = 1'b1;
            endcase
            step();
            cyc++;
            if (cyc == 1) check("dump_lat1", 64'(o_rd_valid), 64'(n != 0));
        end
        i_rd_ready = 1'b0;
        if (cyc >= 300) begin
            n_checks++;
            n_fail++;
            $display("FAIL dump_timeout: got %0d records left, expected 0", exp_q.size());
        end
        if (mode == 2) check("dump_cycles", 64'(cyc), 64'(n + 1));
        check("dump_q_empty",   64'(exp_q.size()), 64'd0);
        check("dump_done",      64'(o_done), 64'd1);
        check("dump_valid_low", 64'(o_rd_valid), 64'd0);
    endtask

    // Replay monitor: scoreboard pops on handshakes, stall stability checks.
    always @(negedge i_clk) begin
        if (!i_rst_n) begin
            prev_hold = 1'b0;
        end else begin
            if (prev_hold) begin
                check("rd_hold_valid", 64'(o_rd_valid), 64'd1);
                check("rd_hold_data",  64'(o_rd_data), 64'(prev_data));
            end
            if (o_rd_valid && i_rd_ready) begin
                last_rd = o_rd_data;
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL rd_unexpected: got record %0h, expected none", o_rd_data);
                end else begin
                    mon_exp = exp_q.pop_front();
                    check("rd_data", 64'(o_rd_data), 64'(mon_exp));
                end
            end
            prev_hold = o_rd_valid && !i_rd_ready;
            prev_data = o_rd_data;
        end
    end

    initial begin
        i_rst_n = 1'b0; i_start = 1'b0; i_stop = 1'b0; i_valid = 1'b0; i_32_s = '0;
        i_ov_flag = 1'b0; i_un_flag = 1'b0; i_add_sub = 1'b0; i_dump_start = 1'b0;
        i_rd_ready = 1'b0; last_rd = '0;
        m_cap = 1'b0; m_done = 1'b0;
        model_clear();
        repeat (3) step();
        check("rst_ready",  64'(o_ready), 64'd0);
        check("rst_rd_vld", 64'(o_rd_valid), 64'd0);
        check_stats("rst");
        i_rst_n = 1'b1;
        step();

        // Four known results, then stop.
        do_start();
        cap(1'b1, 32'h40b00000, 1'b0, 1'b0, 1'b0, 1'b0);
        cap(1'b1, 32'h400ccccd, 1'b0, 1'b0, 1'b0, 1'b0);
`ifdef FPU_COLLECT_CHECKSUM_EN
        check("chk_two", 64'(o_checksum), 64'hC16CCCCD);
`endif
        cap(1'b1, 32'h7f800000, 1'b1, 1'b0, 1'b0, 1'b0);
        cap(1'b1, 32'h00000000, 1'b0, 1'b1, 1'b1, 1'b0);
        cap(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1);
        check("t1_count", 64'(o_count), 64'd4);
        check("t1_ov",    64'(o_ov_cnt), 64'd1);
        check("t1_un",    64'(o_un_cnt), 64'd1);
        check("t1_done",  64'(o_done), 64'd1);
        check_stats("t1");
        dump(0);
        check("t1_last", 64'(last_rd), 64'h5_0000_0000);
        dump(2);

        // Fill to depth with valid held high.
        do_start();
        for (int i = 0; i < 40; i++) cap(1'b1, $urandom, 1'($urandom_range(0, 1)),
                                         1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0);
        check("fill_count", 64'(o_count), 64'd32);
        check_stats("fill");
        dump(2);
        dump(1);

        // Stop together with the third accept.
        do_start();
        cap(1'b1, $urandom, 1'b0, 1'b0, 1'b0, 1'b0);
        cap(1'b1, $urandom, 1'b1, 1'b0, 1'b1, 1'b0);
        cap(1'b1, $urandom, 1'b0, 1'b1, 1'b0, 1'b1);
        check("stop_count", 64'(o_count), 64'd3);
        check_stats("stop");
        dump(1);

        // Randomized capture/replay rounds.
        for (int r = 0; r < 4; r++) begin
            int len;
            len = $urandom_range(1, 45);
            do_start();
            for (int i = 0; i < len; i++) cap(1'($urandom_range(0, 1)), $urandom,
                                              1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                                              1'($urandom_range(0, 1)), 1'($urandom_range(0, 19) == 0));
            cap(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1);
            check_stats("rnd");
            dump(1);
        end

        // Empty capture then dump.
        do_start();
        cap(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1);
        check_stats("empty");
        dump(2);

        // Reset in the middle of a full dump.
        do_start();
        for (int i = 0; i < 32; i++) cap(1'b1, $urandom, 1'b0, 1'b0, 1'b0, 1'b0);
        foreach (m_buf[i]) exp_q.push_back(m_buf[i]);
        i_dump_start = 1'b1;
        step();
        i_dump_start = 1'b0;
        i_rd_ready   = 1'b1;
        repeat (6) step();
        i_rst_n = 1'b0;
        #1;
        check("rstd_valid", 64'(o_rd_valid), 64'd0);
        check("rstd_busy",  64'(o_busy), 64'd0);
        check("rstd_done",  64'(o_done), 64'd0);
        check("rstd_count", 64'(o_count), 64'd0);
        exp_q.delete();
        i_rd_ready = 1'b0;
        m_cap = 1'b0; m_done = 1'b0;
        model_clear();
        step();
        i_rst_n = 1'b1;
        step();
        check_stats("post_rst");

        // Recovery after reset.
        do_start();
        for (int i = 0; i < 5; i++) cap(1'b1, $urandom, 1'($urandom_range(0, 1)), 1'b0, 1'b1, 1'b0);
        cap(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1);
        check_stats("recov");
        dump(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
